// File: rtl/cpu_pkg.sv
// Shared CPU constants for the register file and its write-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int         REG_COUNT  = 31;
    localparam int         REG_IDX_W  = 5;
    localparam int         XLEN       = 32;
    // Index 31 has no backing register; writes aimed at it are dropped.
    localparam logic [4:0] INVALID_RD = 5'd31;

endpackage : cpu_pkg

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set request after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller masks req to withhold grants.
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from ptr+1 for N slots; the first set request wins.
    always_comb begin
        int cand;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int off = 1; off <= N; off++) begin
            cand = (int'(ptr) + off) % N;
            if (!any && req[IDX_W'(cand)]) begin
                any                = 1'b1;
                gnt[IDX_W'(cand)]  = 1'b1;
                idx                = IDX_W'(cand);
            end
        end
    end

endmodule : rr_pick

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ units.
// Latency: grant same cycle as valid; registered write one cycle after transfer.
// Backpressure: wb_stall withholds every ready; unserved requesters hold valid.
module reg_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = XLEN,
    parameter int ADDR_W  = REG_IDX_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb_stall,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      reg_wrt_en,
    output logic [ADDR_W-1:0]         rd,
    output logic [DATA_W-1:0]         rd_data,
    output logic [7:0]                drop_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   last_grant;
    logic [PTR_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_any;
    logic [NUM_REQ-1:0] req_elig;
    logic               xfer;
    logic [ADDR_W-1:0]  sel_rd;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_drop;

    // A stall removes every requester from contention for this cycle only;
    // the pointer is untouched, so the grant after the stall is unchanged.
    assign req_elig = req_valid & {NUM_REQ{~wb_stall}};

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (PTR_W)
    ) u_pick (
        .req (req_elig),
        .ptr (last_grant),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // No grant may escape while reset is held.
    assign req_ready = pick_gnt & {NUM_REQ{rst_n}};
    assign xfer      = pick_any & rst_n;

    assign sel_rd   = req_rd[int'(pick_idx)*ADDR_W +: ADDR_W];
    assign sel_data = req_data[int'(pick_idx)*DATA_W +: DATA_W];
    assign sel_drop = (sel_rd == ADDR_W'(INVALID_RD));

    // Pointer advances only on a transfer; reset leaves requester 0 first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PTR_W'(NUM_REQ - 1);
        end else if (xfer) begin
            last_grant <= pick_idx;
        end
    end

    // Write register: enable pulses for one cycle per real write; index/data hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_wrt_en <= 1'b0;
            rd         <= '0;
            rd_data    <= '0;
        end else begin
            reg_wrt_en <= xfer && !sel_drop;
            if (xfer && !sel_drop) begin
                rd      <= sel_rd;
                rd_data <= sel_data;
            end
        end
    end

    // Saturating count of writes aimed at the nonexistent register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'd0;
        end else if (xfer && sel_drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule : reg_wb_arbiter

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter with a small register-file model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Every comparison goes through chk().
module tb_reg_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk;
    logic              rst_n;
    logic              wb_stall;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_rd;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              reg_wrt_en;
    logic [AW-1:0]     rd;
    logic [DW-1:0]     rd_data;
    logic [7:0]        drop_cnt;

    logic [DW-1:0]     rf [0:31];

    int n_chk;
    int n_err;

    reg_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_stall   (wb_stall),
        .req_valid  (req_valid),
        .req_rd     (req_rd),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .reg_wrt_en (reg_wrt_en),
        .rd         (rd),
        .rd_data    (rd_data),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: commits the presented write on the rising edge.
    always @(posedge clk) begin
        if (reg_wrt_en) rf[rd] <= rd_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] r, input logic [31:0] d);
        req_valid[i]        = v;
        req_rd[i*AW +: AW]  = r;
        req_data[i*DW +: DW] = d;
    endtask

    // Advance to the next falling edge (input-change point).
    task automatic to_neg();
        @(negedge clk);
    endtask

    // Advance past the next rising edge to sample registered outputs.
    task automatic past_pos();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rot_data [0:2];
    logic        saw_wr;

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rot_data[0] = 32'hA000_0000;
        rot_data[1] = 32'hA111_1111;
        rot_data[2] = 32'hA222_2222;

        // Reset with every requester asking.
        rst_n    = 1'b0;
        wb_stall = 1'b0;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), rot_data[i]);
        #3;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_wen", 32'(reg_wrt_en), 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'h0);
        chk("rst_rd", 32'(rd), 32'h0);
        chk("rst_data", rd_data, 32'h0);
        past_pos();
        chk("rst_ready_clk", 32'(req_ready), 32'h0);

        // Release: rotation 0,1,2,0,1,2 with all three held valid.
        to_neg();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rot_ready%0d", k), 32'(req_ready), 32'(3'b001 << (k % 3)));
            past_pos();
            chk($sformatf("rot_wen%0d", k), 32'(reg_wrt_en), 32'h1);
            chk($sformatf("rot_rd%0d", k), 32'(rd), 32'((k % 3) + 1));
            chk($sformatf("rot_data%0d", k), rd_data, rot_data[k % 3]);
            to_neg();
        end
        req_valid = '0;
        past_pos();
        chk("idle_wen", 32'(reg_wrt_en), 32'h0);
        chk("idle_rd_hold", 32'(rd), 32'h3);
        chk("idle_data_hold", rd_data, rot_data[2]);

        // Single requester 1 (pointer now at 2).
        to_neg();
        set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        chk("single_ready", 32'(req_ready), 32'h2);
        past_pos();
        chk("single_wen", 32'(reg_wrt_en), 32'h1);
        chk("single_rd", 32'(rd), 32'h5);
        chk("single_data", rd_data, 32'hDEAD_BEEF);
        to_neg();
        req_valid = '0;
        past_pos();
        chk("single_rf_x5", rf[5], 32'hDEAD_BEEF);

        // Stall for three cycles with requester 2 waiting (pointer at 1).
        to_neg();
        set_req(2, 1'b1, 5'd9, 32'h0000_0099);
        wb_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall_ready%0d", k), 32'(req_ready), 32'h0);
            past_pos();
            chk($sformatf("stall_wen%0d", k), 32'(reg_wrt_en), 32'h0);
            to_neg();
        end
        wb_stall = 1'b0;
        #1;
        chk("unstall_ready", 32'(req_ready), 32'h4);
        past_pos();
        chk("unstall_wen", 32'(reg_wrt_en), 32'h1);
        chk("unstall_rd", 32'(rd), 32'h9);
        // Stall right after a transfer must not cancel the registered write.
        to_neg();
        req_valid = '0;
        wb_stall  = 1'b1;
        #1;
        chk("post_xfer_stall_wen", 32'(reg_wrt_en), 32'h1);
        to_neg();
        wb_stall = 1'b0;

        // Same destination, pointer at 2: requester 0 then 1; x7 ends at 0x22.
        set_req(0, 1'b1, 5'd7, 32'h11);
        set_req(1, 1'b1, 5'd7, 32'h22);
        #1;
        chk("same_ready0", 32'(req_ready), 32'h1);
        past_pos();
        chk("same_data0", rd_data, 32'h11);
        to_neg();
        req_valid[0] = 1'b0;
        #1;
        chk("same_ready1", 32'(req_ready), 32'h2);
        past_pos();
        chk("same_wen1", 32'(reg_wrt_en), 32'h1);
        chk("same_data1", rd_data, 32'h22);
        to_neg();
        req_valid = '0;
        past_pos();
        chk("same_rf_x7", rf[7], 32'h22);

        // All valid while stalled, stall drops: pointer at 1, so requester 2.
        to_neg();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), rot_data[i]);
        wb_stall = 1'b1;
        #1;
        chk("simul_stalled", 32'(req_ready), 32'h0);
        to_neg();
        wb_stall = 1'b0;
        #1;
        chk("simul_drop_ready", 32'(req_ready), 32'h4);
        past_pos();
        chk("simul_rd", 32'(rd), 32'h3);
        to_neg();
        req_valid = '0;

        // 300 transfers to index 31 from requester 0.
        set_req(0, 1'b1, 5'd31, 32'hBAD0_0031);
        saw_wr = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            past_pos();
            if (reg_wrt_en) saw_wr = 1'b1;
            if (k == 1)   chk("drop_cnt1", 32'(drop_cnt), 32'd1);
            if (k == 254) chk("drop_cnt254", 32'(drop_cnt), 32'd254);
            if (k == 255) chk("drop_cnt255", 32'(drop_cnt), 32'd255);
            to_neg();
        end
        chk("drop_sat", 32'(drop_cnt), 32'd255);
        chk("drop_no_wen", 32'(saw_wr), 32'h0);
        chk("drop_rd_hold", 32'(rd), 32'h3);
        req_valid = '0;

        // Reset in the middle of a registered write.
        set_req(1, 1'b1, 5'd4, 32'h4444_4444);
        past_pos();
        chk("mid_wen_before", 32'(reg_wrt_en), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wen", 32'(reg_wrt_en), 32'h0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        to_neg();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 10), rot_data[i]);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(req_ready), 32'h1);
        past_pos();
        chk("mid_rel_rd", 32'(rd), 32'd10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Watchdog against any unbounded wait.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_reg_wb_arbiter

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Round-robin arbiter that shares the register file's single write port among `NUM_REQ` write-back requesters (ALU, load unit, CSR/misc). It sits between the execution units and the 31-entry register file. Each cycle it accepts at most one request through a valid/ready handshake and drives a registered write (`reg_wrt_en`, `rd`, `rd_data`) one cycle later. Writes aimed at the nonexistent index 31 are accepted but suppressed and counted.

## Interface
- `NUM_REQ`, 3: number of requesters; legal range 2..8.
- `DATA_W`, 32: write data width.
- `ADDR_W`, 5: register index width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `wb_stall`  in  1  freeze; while high, no request is accepted.
- `req_valid`  in  NUM_REQ  per-requester write request.
- `req_rd`  in  NUM_REQ*ADDR_W  packed destination indices; requester i uses bits [i*ADDR_W +: ADDR_W].
- `req_data`  in  NUM_REQ*DATA_W  packed write data, using the same packing.
- `req_ready`  out  NUM_REQ  one-hot or zero grant; combinational.
- `reg_wrt_en`  out  1  register file write enable; registered.
- `rd`  out  ADDR_W  register file write index; registered.
- `rd_data`  out  DATA_W  register file write data; registered.
- `drop_cnt`  out  8  saturating count of suppressed index-31 writes.

## Operation
- **Handshake.** Requester i transfers when `req_valid[i] && req_ready[i]`.
  - A requester holds `valid`, `rd` and `data` stable until the transfer.
  - The arbiter never deasserts `ready` for a held request except by granting another requester or by `wb_stall`.
- **Arbitration.**
  - Priority starts at `last_grant+1` and wraps modulo `NUM_REQ`.
  - `req_ready` is set only for the first valid requester in that order, and only when `wb_stall==0`.
  - `last_grant` updates to the granted index on every transfer. It is unchanged in idle or stalled cycles.
- **Write stage.**
  - On a transfer with `rd` ≤ 30: next cycle `reg_wrt_en=1`, `rd` = granted index, `rd_data` = granted data.
  - On a transfer with `rd==31`: next cycle `reg_wrt_en=0`, and `drop_cnt` increments (saturates at 255).
  - With no transfer: next cycle `reg_wrt_en=0`. `rd` and `rd_data` hold their previous values.
- **Same-destination requests.** Two requesters targeting the same `rd` are serialized in round-robin order. The later grant's data wins in the register file.
- **Index 0.** `rd==0` is an ordinary, writable register; it is not hardwired to zero.

## Timing
- Grant is combinational: `valid` to `ready` in the same cycle.
- Transfer to `reg_wrt_en`: 1 cycle. The register file commits on the edge after that.
- Throughput: one write per cycle when unstalled.
- Fairness: a continuously valid requester is granted within `NUM_REQ` unstalled cycles.
- Reset values:
  - `last_grant` = `NUM_REQ-1`, so requester 0 has first priority.
  - `reg_wrt_en`=0, `rd`=0, `rd_data`=0, `drop_cnt`=0.
  - `req_ready`=0 while `rst_n` is low.
- **Reset mid-operation.** An in-flight registered write is discarded: `reg_wrt_en` drops immediately, asynchronously. Requesters must re-present their requests after reset.
- **Stall.**
  - `wb_stall` high blocks all grants in that cycle.
  - A write already registered is still presented: a stall asserted in the cycle after a transfer does not cancel `reg_wrt_en`.
- **Simultaneous events.** All requesters valid, with stall dropping in the same cycle: the grant follows the current pointer exactly as if there had been no stall.

## Structure
- Shared package `cpu_pkg`:
  - `REG_COUNT` = 31.
  - `REG_IDX_W` = 5.
  - `XLEN` = 32.
  - `INVALID_RD` = 5'd31.
- Sub-module `rr_pick`: a pure combinational round-robin priority picker.
  - Inputs: request vector and pointer.
  - Output: one-hot grant plus the encoded index.
  - Instantiated once.
- The top level holds `last_grant`, the output write register and the drop counter.

## Test plan
- **Reset:** assert `rst_n`=0 with all `req_valid`=1 -> `req_ready`=0, `reg_wrt_en`=0, `drop_cnt`=0. Release -> first grant to requester 0.
- **Single requester:** requester 1 sends `rd`=5, data=0xDEADBEEF -> same-cycle `ready`; next cycle `reg_wrt_en`=1, `rd`=5, `rd_data`=0xDEADBEEF. A register-file read of x5 then returns 0xDEADBEEF.
- **Rotation:** all three valid and held for 6 cycles -> grants in order 0,1,2,0,1,2; 6 back-to-back writes.
- **Stall:** requester 2 valid, `wb_stall` high for 3 cycles -> no `ready` and `reg_wrt_en`=0 throughout. Grant in the first cycle after stall drops.
- **Index 31:** 300 transfers with `rd`=31 -> `reg_wrt_en` never asserted; `drop_cnt` reaches 255 and stays there.
- **Same rd:** requesters 0 and 1 both target `rd`=7 with 0x11 and 0x22 -> two writes in consecutive cycles; x7 ends at 0x22.
